// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: op codes, instruction layout, NOP word, FSM states.
package calc_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int INSTR_W  = 12;
  localparam int HALT_BIT = 11;
  localparam int CTRL_LSB = 8;
  localparam int RD_LSB   = 6;
  localparam int WE_LSB   = 4;
  localparam int IMM_LSB  = 0;

  // r0 = r0 + 0: safe to present while the calculator writes every cycle
  localparam logic [INSTR_W-1:0] NOP_WORD = 12'h200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic op_illegal(input logic [2:0] op);
    return !(op inside {OP_AND, OP_ADD, OP_SUB, OP_SLT});
  endfunction

endpackage

// File: rtl/calc_prog_mem.sv
// Program store: DEPTH x 12, synchronous write, combinational read. Contents are not reset.
module calc_prog_mem
  import calc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [DEPTH-1:0][INSTR_W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// Program counter + FSM issuing one calculator instruction per clock from calc_prog_mem.
// Optional CALC_SEQ_ILLEGAL_TRAP_EN: stop the run with a sticky error on an unsupported op code.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [11:0]       prog_data,
  input  logic              start,
  output logic [2:0]        control,
  output logic [1:0]        rd_addr,
  output logic [1:0]        we_addr,
  output logic [3:0]        immediate,
  output logic              issue_valid,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W:0]   issued_cnt
);

  seq_state_e         state;
  logic [ADDR_W-1:0]  fetch_idx;
  logic [INSTR_W-1:0] word;
  logic               halt, illegal, stop, last, start_ok, do_eval;
  logic [ADDR_W:0]    cnt_base, cnt_inc;

  calc_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (prog_we && state == ST_IDLE),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (fetch_idx),
    .rdata (word)
  );

  // The output registers are loaded straight from the fetched word, so pc
  // always names the word currently on the outputs.
  assign fetch_idx = (state == ST_IDLE) ? '0 : pc + ADDR_W'(1);
  assign last      = (pc == ADDR_W'(DEPTH - 1));
  assign start_ok  = (state == ST_IDLE) && start && !prog_we;
  assign do_eval   = start_ok || (state == ST_RUN && !last);
  assign halt      = word[HALT_BIT];
`ifdef CALC_SEQ_ILLEGAL_TRAP_EN
  assign illegal   = !halt && op_illegal(word[CTRL_LSB +: 3]);
`else
  assign illegal   = 1'b0;
`endif
  assign stop      = halt || illegal;
  assign cnt_base  = start_ok ? '0 : issued_cnt;
  assign cnt_inc   = (cnt_base == (ADDR_W+1)'(DEPTH)) ? cnt_base : cnt_base + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      control     <= OP_ADD;
      rd_addr     <= '0;
      we_addr     <= '0;
      immediate   <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      pc          <= '0;
      issued_cnt  <= '0;
    end else begin
      control     <= NOP_WORD[CTRL_LSB +: 3];
      rd_addr     <= NOP_WORD[RD_LSB +: 2];
      we_addr     <= NOP_WORD[WE_LSB +: 2];
      immediate   <= NOP_WORD[IMM_LSB +: 4];
      issue_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      if (start_ok) error <= 1'b0;
      if (do_eval) begin
        pc <= fetch_idx;
        if (stop) begin
          state      <= ST_DONE;
          done       <= 1'b1;
          issued_cnt <= cnt_base;
          if (illegal) error <= 1'b1;
        end else begin
          state       <= ST_RUN;
          busy        <= 1'b1;
          issue_valid <= 1'b1;
          control     <= word[CTRL_LSB +: 3];
          rd_addr     <= word[RD_LSB +: 2];
          we_addr     <= word[WE_LSB +: 2];
          immediate   <= word[IMM_LSB +: 4];
          issued_cnt  <= cnt_inc;
        end
      end else if (state == ST_RUN) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Upstream stage of the calculator: a small program memory plus a program counter and FSM that issues one calculator instruction per clock.
- Drives the calculator's control, rd_addr, we_addr and immediate inputs directly.
- The calculator writes on every posedge and has no enable, so the sequencer drives a harmless NOP whenever it is not issuing.

Parameters:
DEPTH, 16, number of program words
ADDR_W, 4, program address width; must satisfy 2**ADDR_W == DEPTH

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high reset
prog_we  input  1  program write strobe; ignored unless in IDLE
prog_addr  input  ADDR_W  program write address
prog_data  input  12  instruction word: [11]=HALT, [10:8]=control, [7:6]=rd_addr, [5:4]=we_addr, [3:0]=immediate
start  input  1  run request; sampled only in IDLE
control  output  3  calculator op code (registered)
rd_addr  output  2  calculator source register (registered)
we_addr  output  2  calculator destination register (registered)
immediate  output  4  signed immediate (registered)
issue_valid  output  1  high when the output fields hold a real program instruction
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a run ends
error  output  1  illegal-op flag; exists only with the optional feature
pc  output  ADDR_W  address of the word currently on the outputs
issued_cnt  output  ADDR_W+1  number of instructions issued in the current or last run

Behaviour:
- NOP: control=010 (add), rd_addr=00, we_addr=00, immediate=0, i.e. r0=r0+0.
- Reset (async, any time, including mid-run): state=IDLE; outputs=NOP; issue_valid=0, busy=0, done=0, error=0; pc=0; issued_cnt=0. Program memory is not reset.
- Program memory: synchronous write on posedge when prog_we=1 and state=IDLE; writes while not in IDLE are dropped.
- States: IDLE, RUN, DONE.
- IDLE: outputs NOP. If start=1 at a posedge (prog_we takes priority if both are high):
  - go to RUN;
  - fetch word 0;
  - clear issued_cnt and error.
- RUN, each cycle, evaluating the fetched word mem[pc]:
  - HALT=0: fields appear on the outputs with issue_valid=1; issued_cnt increments. The calculator consumes the word at the next posedge.
  - pc advances by 1 each cycle.
  - HALT=1: the word is not issued; outputs=NOP, issue_valid=0, next state DONE.
  - Last slot: after issuing the word at pc=DEPTH-1, next state is DONE. No wrap-around.
- Latency: start sampled at edge N puts word 0 on the outputs after edge N; word k appears after edge N+k.
- DONE: lasts exactly 1 cycle with done=1; outputs=NOP; then IDLE.
  - pc and issued_cnt hold their final values until the next start.
- start while RUN or DONE is ignored (no queuing).
- busy=1 exactly while in RUN.
- issued_cnt saturates at DEPTH.

Optional Feature:
CALC_SEQ_ILLEGAL_TRAP_EN
- Defined: a fetched non-HALT word whose control is 001, 011, 100 or 101 is not issued; outputs=NOP, issue_valid=0, next state DONE. error goes high with done and stays high (sticky) until the next accepted start or reset.
- Undefined: all control codes are issued unchanged; the error port is tied to 0.

Decomposition:
- Shared package calc_pkg:
  - op constants OP_AND=3'b000, OP_ADD=3'b010, OP_SUB=3'b110, OP_SLT=3'b111;
  - instruction field bit positions;
  - NOP word 12'h200;
  - HALT bit index;
  - FSM state encoding.
- Sub-module calc_prog_mem: DEPTH x 12 array, synchronous write, combinational read indexed by pc.
- The FSM, pc and output registers live in calc_sequencer.

Test Plan:
- Reset: assert reset mid-run at pc=3 -> on the same cycle, outputs=NOP, busy=0, pc=0, issue_valid=0; no further issues after reset is released.
- Basic run: load 0x202, 0x61E, 0x800 at 0..2; pulse start -> cycle+1 fields (010,00,00,+2), cycle+2 fields (110,00,01,-2); then NOP with done=1 for 1 cycle; issued_cnt=2.
- Full program: load 16 words with HALT=0, then start -> 16 consecutive issue_valid cycles, pc 0..15, then done, issued_cnt=16, busy low afterwards.
- Ignored inputs: pulse start and prog_we to addr 1 while RUN -> no restart; mem[1] unchanged (verified by a second run).
- Immediate HALT: mem[0]=0x800 -> no issue_valid at all; done one cycle after start; issued_cnt=0.
- Illegal op: with CALC_SEQ_ILLEGAL_TRAP_EN, mem[1]=0x3xx (control=011) -> word 0 issued, then done=1 and error=1 (held until next start). Without the macro -> word issued with control=011.
